memoria_datos_param: RTL and testbench

//  Parametrised data memory for the single-cycle processor datapath, successor to the fixed 32-bit word store.

---
 rtl/memoria_datos_param_if.sv | 26 ++
 rtl/memoria_datos_param.sv | 123 ++++++++++++
 tb/tb_memoria_datos_param.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/memoria_datos_param_if.sv
// Bus bundle for memoria_datos_param: request side (EscrMem, LeerMem, Tamano,
// SinSigno, Direc, Datain) and response side (Dataout, Valido, ErrAlin, Ocupado).
interface memoria_datos_param_if #(
  parameter int ANCHO_DIREC = 8
);
  logic                   EscrMem;
  logic                   LeerMem;
  logic [1:0]             Tamano;
  logic                   SinSigno;
  logic [ANCHO_DIREC-1:0] Direc;
  logic [31:0]            Datain;
  logic [31:0]            Dataout;
  logic                   Valido;
  logic                   ErrAlin;
  logic                   Ocupado;

  modport master (
    output EscrMem, LeerMem, Tamano, SinSigno, Direc, Datain,
    input  Dataout, Valido, ErrAlin, Ocupado
  );

  modport slave (
    input  EscrMem, LeerMem, Tamano, SinSigno, Direc, Datain,
    output Dataout, Valido, ErrAlin, Ocupado
  );
endinterface

// File: rtl/memoria_datos_param.sv
// Byte-addressed little-endian data memory, byte/half/word access, registered
// read with Valido pulse, ErrAlin on misaligned/illegal requests, optional clear.
// Ports: clk, rst (async high), m (slave side of memoria_datos_param_if).
module memoria_datos_param #(
  parameter int ANCHO_DIREC = 8,
  parameter int LIMPIAR     = 1
) (
  input  logic clk,
  input  logic rst,
  memoria_datos_param_if.slave m
);
  localparam int AW   = ANCHO_DIREC - 2;
  localparam int PROF = 2 ** AW;

  typedef enum logic {
    LIMPIANDO,
    LISTO
  } estado_t;

  estado_t       estado;
  logic [AW-1:0] cnt;
  logic [31:0]   mem [PROF];

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          legal;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   palabra;
  logic [7:0]    byte_l;
  logic [15:0]   half_l;
  logic [31:0]   rdata;
  logic          listo;
  logic          acc_wr;
  logic          acc_rd;
  logic          rech;
  logic          clr_we;

  always_comb begin
    idx    = m.Direc[ANCHO_DIREC-1:2];
    off    = m.Direc[1:0];
    legal  = 1'b0;
    be     = 4'b0000;
    wdata  = m.Datain;
    case (m.Tamano)
      2'b00: begin
        legal = 1'b1;
        be    = 4'b0001 << off;
        wdata = {4{m.Datain[7:0]}};
      end
      2'b01: begin
        legal = ~off[0];
        be    = 4'b0011 << off;
        wdata = {2{m.Datain[15:0]}};
      end
      2'b10: begin
        legal = (off == 2'b00);
        be    = 4'b1111;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // Lane extraction: half offset is known even when legal,
  // so off[1] alone picks the half.
  always_comb begin
    palabra = mem[idx];
    byte_l  = palabra[{off, 3'b000} +: 8];
    half_l  = off[1] ? palabra[31:16] : palabra[15:0];
    rdata   = palabra;
    case (m.Tamano)
      2'b00: rdata = m.SinSigno ? {24'b0, byte_l}
                                : {{24{byte_l[7]}}, byte_l};
      2'b01: rdata = m.SinSigno ? {16'b0, half_l}
                                : {{16{half_l[15]}}, half_l};
      default: rdata = palabra;
    endcase
  end

  always_comb begin
    listo  = (estado == LISTO) && !rst;
    acc_wr = listo && m.EscrMem && legal;
    acc_rd = listo && m.LeerMem && !m.EscrMem && legal;
    rech   = listo && (m.EscrMem || m.LeerMem) && !legal;
    clr_we = (estado == LIMPIANDO) && !rst;
  end

  // Array has no reset; contents come from the clear sweep.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[cnt] <= '0;
    end else if (acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= (LIMPIAR != 0) ? LIMPIANDO : LISTO;
      cnt       <= '0;
      m.Dataout <= '0;
      m.Valido  <= 1'b0;
      m.ErrAlin <= 1'b0;
    end else begin
      m.Valido  <= acc_rd;
      m.ErrAlin <= rech;
      if (acc_rd) m.Dataout <= rdata;
      case (estado)
        LIMPIANDO: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(PROF - 1)) estado <= LISTO;
        end
        default: estado <= LISTO;
      endcase
    end
  end

  assign m.Ocupado = (estado == LIMPIANDO);
endmodule

// File: tb/tb_memoria_datos_param.sv
// Testbench for memoria_datos_param: vector table, randomized ops vs a
// byte-array reference model, and reset/clear sequences.
module tb_memoria_datos_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memoria_datos_param_if #(.ANCHO_DIREC(8)) bus ();

  memoria_datos_param #(.ANCHO_DIREC(8), .LIMPIAR(1)) dut (
    .clk(clk),
    .rst(rst),
    .m  (bus)
  );

  typedef struct {
    logic        escr;
    logic        leer;
    logic [1:0]  tam;
    logic        ss;
    logic [7:0]  dir;
    logic [31:0] din;
    logic [31:0] dout;
    logic        val;
    logic        err;
  } vec_t;

  int nvec = 0;
  int nmis = 0;
  logic [7:0]  rm [256];
  logic [31:0] last_dout = '0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic l, input logic [1:0] t,
                       input logic s, input logic [7:0] d,
                       input logic [31:0] di);
    bus.EscrMem  = e;
    bus.LeerMem  = l;
    bus.Tamano   = t;
    bus.SinSigno = s;
    bus.Direc    = d;
    bus.Datain   = di;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b10, 1'b0, 8'h00, 32'h0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) rm[i] = 8'h00;
    last_dout = '0;
  endtask

  // Reference: byte-level memory, request rules from first principles.
  task automatic model_step(input logic e, input logic l,
                            input logic [1:0] t, input logic s,
                            input logic [7:0] d, input logic [31:0] di,
                            output logic [31:0] edo, output logic ev,
                            output logic ee);
    int nb;
    bit ok;
    logic [31:0] v;
    nb = 1 << t;
    ok = (t == 0) || (t == 1 && d % 2 == 0) || (t == 2 && d % 4 == 0);
    ev = 1'b0;
    ee = 1'b0;
    if (e || l) begin
      if (!ok) begin
        ee = 1'b1;
      end else if (e) begin
        for (int i = 0; i < nb; i++) rm[int'(d) + i] = di[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rm[int'(d) + i];
        if (t == 0 && !s && v[7])  v[31:8]  = '1;
        if (t == 1 && !s && v[15]) v[31:16] = '1;
        last_dout = v;
        ev = 1'b1;
      end
    end
    edo = last_dout;
  endtask

  task automatic run_op(input logic e, input logic l, input logic [1:0] t,
                        input logic s, input logic [7:0] d,
                        input logic [31:0] di, input logic [31:0] edo,
                        input logic ev, input logic ee, input string nm);
    drive(e, l, t, s, d, di);
    tick();
    chk({nm, ".dout"}, bus.Dataout, edo);
    chk({nm, ".val"}, {31'b0, bus.Valido}, {31'b0, ev});
    chk({nm, ".err"}, {31'b0, bus.ErrAlin}, {31'b0, ee});
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (bus.Ocupado && n < 200) begin
      tick();
      n++;
    end
  endtask

  vec_t tbl[$];
  logic [31:0] edo;
  logic ev, ee;
  int n;
  bit seen;

  initial begin
    idle();
    model_clear();
    tick();
    tick();
    chk("rst.dout", bus.Dataout, 32'h0);
    chk("rst.val", {31'b0, bus.Valido}, 32'h0);
    chk("rst.err", {31'b0, bus.ErrAlin}, 32'h0);
    chk("rst.ocup", {31'b0, bus.Ocupado}, 32'h1);
    rst = 1'b0;
    wait_clear(n);
    chk("clear.len", n, 64);

    run_op(0, 1, 2'b10, 0, 8'h00, 0, 32'h0, 1, 0, "clr_rd00");
    run_op(0, 1, 2'b10, 0, 8'hFC, 0, 32'h0, 1, 0, "clr_rdFC");

    tbl.push_back('{1, 0, 2'b10, 0, 8'h10, 32'h8899AABB, 32'h0, 0, 0});
    tbl.push_back('{0, 1, 2'b00, 0, 8'h13, 0, 32'hFFFFFF88, 1, 0});
    tbl.push_back('{0, 1, 2'b00, 1, 8'h13, 0, 32'h00000088, 1, 0});
    tbl.push_back('{1, 0, 2'b00, 0, 8'h11, 32'h5A, 32'h00000088, 0, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 8'h10, 0, 32'h88995ABB, 1, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 8'h12, 0, 32'hFFFF8899, 1, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 8'h06, 0, 32'hFFFF8899, 0, 1});
    tbl.push_back('{1, 0, 2'b01, 0, 8'h03, 32'hFFFF, 32'hFFFF8899, 0, 1});
    tbl.push_back('{0, 1, 2'b11, 0, 8'h10, 0, 32'hFFFF8899, 0, 1});
    tbl.push_back('{1, 0, 2'b11, 0, 8'h10, 32'h1, 32'hFFFF8899, 0, 1});
    tbl.push_back('{0, 1, 2'b10, 0, 8'h10, 0, 32'h88995ABB, 1, 0});
    tbl.push_back('{0, 1, 2'b01, 1, 8'h02, 0, 32'h00000000, 1, 0});
    tbl.push_back('{0, 0, 2'b10, 0, 8'h10, 0, 32'h00000000, 0, 0});
    tbl.push_back('{1, 1, 2'b10, 0, 8'h20, 32'h12345678, 32'h0, 0, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 8'h20, 0, 32'h12345678, 1, 0});
    tbl.push_back('{0, 1, 2'b01, 1, 8'h22, 0, 32'h00001234, 1, 0});
    tbl.push_back('{0, 1, 2'b01, 0, 8'h20, 0, 32'h00005678, 1, 0});
    tbl.push_back('{0, 1, 2'b00, 0, 8'h21, 0, 32'h00000056, 1, 0});
    tbl.push_back('{1, 0, 2'b01, 0, 8'h02, 32'h1111CAFE, 32'h56, 0, 0});
    tbl.push_back('{0, 1, 2'b10, 0, 8'h00, 0, 32'hCAFE0000, 1, 0});
    tbl.push_back('{0, 1, 2'b00, 0, 8'h03, 0, 32'hFFFFFFCA, 1, 0});

    foreach (tbl[i]) begin
      model_step(tbl[i].escr, tbl[i].leer, tbl[i].tam, tbl[i].ss,
                 tbl[i].dir, tbl[i].din, edo, ev, ee);
      run_op(tbl[i].escr, tbl[i].leer, tbl[i].tam, tbl[i].ss, tbl[i].dir,
             tbl[i].din, tbl[i].dout, tbl[i].val, tbl[i].err,
             $sformatf("vec%0d", i));
    end

    for (int k = 0; k < 400; k++) begin
      logic e, l, s;
      logic [1:0] t;
      logic [7:0] d;
      logic [31:0] di;
      e  = ($urandom_range(0, 2) == 0);
      l  = ($urandom_range(0, 1) == 0);
      s  = $urandom_range(0, 1);
      t  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom)
           : 8'($urandom_range(0, 15) << 2) | 8'($urandom_range(0, 1) << 1);
      di = $urandom;
      model_step(e, l, t, s, d, di, edo, ev, ee);
      run_op(e, l, t, s, d, di, edo, ev, ee, $sformatf("rnd%0d", k));
    end

    // Reset in the middle of a read: outputs clear without a clock edge.
    run_op(1, 0, 2'b10, 0, 8'h40, 32'hDEADBEEF, last_dout, 0, 0, "pre_w");
    run_op(0, 1, 2'b10, 0, 8'h40, 0, 32'hDEADBEEF, 1, 0, "pre_r");
    drive(0, 1, 2'b10, 0, 8'h40, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_rd.dout", bus.Dataout, 32'h0);
    chk("rst_rd.val", {31'b0, bus.Valido}, 32'h0);
    chk("rst_rd.ocup", {31'b0, bus.Ocupado}, 32'h1);
    tick();
    idle();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    chk("mid.ocup", {31'b0, bus.Ocupado}, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("mid.dout", bus.Dataout, 32'h0);
    tick();
    rst = 1'b0;
    drive(1, 1, 2'b11, 0, 8'h41, 32'hFFFFFFFF);
    seen = 0;
    n = 0;
    while (bus.Ocupado && n < 200) begin
      tick();
      n++;
      if (bus.Ocupado && (bus.ErrAlin || bus.Valido)) seen = 1;
    end
    idle();
    chk("clear2.len", n, 64);
    chk("clear2.quiet", {31'b0, seen}, 32'h0);
    model_clear();
    run_op(0, 1, 2'b10, 0, 8'h40, 0, 32'h0, 1, 0, "post_rd40");
    run_op(0, 1, 2'b10, 0, 8'h00, 0, 32'h0, 1, 0, "post_rd00");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
